dma_rx_sink: RTL and testbench
==============================

# dma_rx_sink

Receiving end of the tiny DMA output stream. Captures 7-bit words and the done strobe produced by the DMA core into an 8-entry FIFO. Maintains a word count, a running checksum and a sticky overflow flag, and exposes a pop-style read port. Sits beside the DMA core in the top level; it is also used as the bench-side scoreboard sink.

## Interface

Parameters:
- DATA_W, 7: width of a stream word; matches the DMA data bus.
- DEPTH, 8: number of FIFO entries; power of two, minimum 2.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- data_in, input, DATA_W: stream word from the DMA core.
- data_valid, input, 1: data_in is valid this cycle.
- done_in, input, 1: end-of-transfer strobe from the DMA core (its dma_done).
- clear, input, 1: synchronous clear; empties the FIFO, zeroes the count and checksum, returns to IDLE.
- rd_en, input, 1: pop request.
- rd_data, output, DATA_W: popped word; registered.
- rd_valid, output, 1: high for one cycle when rd_data holds a newly popped word.
- count, output, $clog2(DEPTH)+1: current FIFO occupancy.
- rx_total, output, 8: words accepted since the last clear; saturates at 255.
- checksum, output, 8: sum modulo 256 of accepted words, each zero-extended to 8 bits.
- overflow, output, 1: sticky; a word was dropped because the FIFO was full.
- rx_done, output, 1: high while in DONE.

## Operation

- States:
  - IDLE: waiting for the first word.
  - RECV: accepting words.
  - DONE: transfer complete; further data_valid is ignored.
- Transitions:
  - IDLE→RECV on data_valid; that word is written.
  - IDLE→DONE on done_in without data_valid, which is a zero-length transfer.
  - RECV→DONE on done_in.
  - DONE→IDLE only on clear.
- Simultaneous data_valid and done_in, in IDLE or RECV: the word is written, then the state goes to DONE.
- Write acceptance: in IDLE/RECV, data_valid and not full. An accepted word increments count, increments rx_total (saturating) and adds to checksum.
- Write while full: the word is dropped; overflow is set; count, checksum and rx_total are unchanged.
- Write and pop in the same cycle when full: the pop frees a slot; the write is accepted, count stays DEPTH, and overflow is not set.
- Pop: rd_en while count>0 reads the head entry. The read pointer advances and count decrements. rd_data and rd_valid update on the next edge.
- Pop while empty: ignored; rd_valid=0 and rd_data holds its previous value.
- Pop and write in the same cycle when empty: the write is accepted and the pop is ignored; count becomes 1.
- Pops are allowed in every state, including DONE.
- Pointers: log2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
- clear priority: clear overrides every other input in the same cycle. The same-cycle write and pop are discarded, all pointers, counters and overflow go to 0, state goes to IDLE, and rd_valid=0. rd_data is not cleared.

## Timing

- Reset (asynchronous assert, synchronous to the release edge):
  - state=IDLE;
  - rd_data=0, rd_valid=0, count=0, rx_total=0, checksum=0, overflow=0, rx_done=0;
  - FIFO storage contents don't-care.
- Write latency: word sampled at edge N; count, rx_total and checksum reflect it after edge N.
- Read latency: rd_en sampled at edge N; rd_data/rd_valid valid after edge N, for one cycle.
- Pop-after-write: a word written at edge N can be popped by rd_en sampled at edge N+1.
- rx_done rises the cycle after done_in is sampled.
- Reset asserted mid-transfer: all outputs return to their reset values immediately; buffered words are lost.

## Test plan

- Basic stream: after reset, push 0x11, 0x22, 0x33 on consecutive cycles, then done_in. Expect count=3, rx_total=3, checksum=0x66, rx_done=1. Three pops return 0x11, 0x22, 0x33 with rd_valid pulses, ending at count=0.
- Overflow: push 10 words of 0x7F with no pops. Expect count=8, rx_total=8, checksum=0xF8, overflow=1. Pops return exactly 8 words.
- Full with simultaneous push/pop: fill 8 words 0x01..0x08, then push 0x09 together with rd_en. Expect rd_data=0x01, count=8, overflow=0. Remaining pops return 0x02..0x09, which exercises pointer wrap.
- Done coincident with data: data_valid=1 with 0x05 and done_in=1 in the same cycle from RECV. Expect the word stored and rx_done=1. A later push of 0x06 is ignored and count is unchanged.
- Clear priority: in RECV with 4 words buffered, assert clear together with data_valid and rd_en. Expect count=0, checksum=0, overflow=0, state IDLE, rd_valid=0 next cycle.
- Empty pop and async reset: rd_en while empty leaves rd_valid=0. Then assert rst_n=0 mid-transfer and check that all outputs read as zero before the next clock edge.

Source files
------------

// File: rtl/dma_rx_sink_if.sv
// Bundle of stream-input, read-port and status signals for dma_rx_sink.
// The sink side takes the slave modport; whoever drives the stream and pops takes master.
interface dma_rx_sink_if #(
    parameter int DATA_W = 7,
    parameter int DEPTH  = 8
);
    logic [DATA_W-1:0]        data_in;
    logic                     data_valid;
    logic                     done_in;
    logic                     clear;
    logic                     rd_en;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_valid;
    logic [$clog2(DEPTH):0]   count;
    logic [7:0]               rx_total;
    logic [7:0]               checksum;
    logic                     overflow;
    logic                     rx_done;

    modport slave (
        input  data_in, data_valid, done_in, clear, rd_en,
        output rd_data, rd_valid, count, rx_total, checksum, overflow, rx_done
    );

    modport master (
        output data_in, data_valid, done_in, clear, rd_en,
        input  rd_data, rd_valid, count, rx_total, checksum, overflow, rx_done
    );
endinterface

// File: rtl/dma_rx_sink.sv
// Receive sink for the DMA output stream: 8-entry FIFO with word count,
// running checksum, sticky overflow and an IDLE/RECV/DONE transfer tracker.
module dma_rx_sink #(
    parameter int DATA_W = 7,
    parameter int DEPTH  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    dma_rx_sink_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic [7:0]         rx_total_q;
    logic [7:0]         checksum_q;
    logic               overflow_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               rd_valid_q;

    logic               full;
    logic               empty;
    logic               accepting;
    logic               do_pop;
    logic               do_write;
    logic               drop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign accepting = (state != DONE);

    // A pop on a full FIFO frees the slot the same-cycle write lands in.
    assign do_pop   = bus.rd_en && !empty && !bus.clear;
    assign do_write = accepting && bus.data_valid && (!full || do_pop) && !bus.clear;
    assign drop     = accepting && bus.data_valid && full && !do_pop && !bus.clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.done_in) begin
                        state_next = DONE;
                    end else if (bus.data_valid) begin
                        state_next = RECV;
                    end
                end
                RECV: begin
                    if (bus.done_in) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Storage has no reset; only the pointers and count define its valid range.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            rx_total_q <= '0;
            checksum_q <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            rx_total_q <= '0;
            checksum_q <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= do_pop;
            if (do_pop) begin
                rd_data_q <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PTR_W'(1);
            end
            if (do_write) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                checksum_q <= checksum_q + 8'(bus.data_in);
                if (rx_total_q != 8'hFF) begin
                    rx_total_q <= rx_total_q + 8'd1;
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            case ({do_write, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.rx_total = rx_total_q;
    assign bus.checksum = checksum_q;
    assign bus.overflow = overflow_q;
    assign bus.rx_done  = (state == DONE);
endmodule

// File: tb/tb_dma_rx_sink.sv
// Directed bench for dma_rx_sink: one task per scenario, each with inline
// checks against hand-computed values.
module tb_dma_rx_sink;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    dma_rx_sink_if #(.DATA_W(7), .DEPTH(8)) bus ();

    dma_rx_sink #(.DATA_W(7), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.done_in    = 1'b0;
        bus.clear      = 1'b0;
        bus.rd_en      = 1'b0;
    endtask

    task automatic do_clear();
        idle_inputs();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic push(input logic [6:0] word);
        bus.data_in    = word;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (bus.count !== 4'd0 || bus.rd_valid !== 1'b0 || bus.rx_done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_during: count=%0d rd_valid=%b rx_done=%b, required 0/0/0",
                     bus.count, bus.rd_valid, bus.rx_done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.rd_data !== 7'h00 || bus.rx_total !== 8'h00 || bus.checksum !== 8'h00 ||
            bus.overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_after: rd_data=%h rx_total=%h checksum=%h overflow=%b, required 0",
                     bus.rd_data, bus.rx_total, bus.checksum, bus.overflow);
        end
    endtask

    task automatic test_basic_stream();
        push(7'h11);
        push(7'h22);
        push(7'h33);
        bus.done_in = 1'b1;
        tick();
        bus.done_in = 1'b0;
        n_checks++;
        if (bus.count !== 4'd3 || bus.rx_total !== 8'd3) begin
            n_fail++;
            $display("[TB] FAIL basic_count: count=%0d rx_total=%0d, required 3/3",
                     bus.count, bus.rx_total);
        end
        n_checks++;
        if (bus.checksum !== 8'h66 || bus.rx_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL basic_sum_done: checksum=%h rx_done=%b, required 66/1",
                     bus.checksum, bus.rx_done);
        end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [6:0] expected;
            expected = 7'(8'h11 * (i + 1));
            tick();
            n_checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== expected) begin
                n_fail++;
                $display("[TB] FAIL basic_pop%0d: rd_valid=%b rd_data=%h, required 1/%h",
                         i, bus.rd_valid, bus.rd_data, expected);
            end
        end
        bus.rd_en = 1'b0;
        tick();
        n_checks++;
        if (bus.rd_valid !== 1'b0 || bus.count !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL basic_drained: rd_valid=%b count=%0d, required 0/0",
                     bus.rd_valid, bus.count);
        end
    endtask

    task automatic test_overflow();
        int pops;
        do_clear();
        for (int i = 0; i < 10; i++) begin
            push(7'h7F);
        end
        n_checks++;
        if (bus.count !== 4'd8 || bus.rx_total !== 8'd8) begin
            n_fail++;
            $display("[TB] FAIL ovf_count: count=%0d rx_total=%0d, required 8/8",
                     bus.count, bus.rx_total);
        end
        n_checks++;
        if (bus.checksum !== 8'hF8 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ovf_flag: checksum=%h overflow=%b, required F8/1",
                     bus.checksum, bus.overflow);
        end
        pops = 0;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.rd_valid === 1'b1) pops++;
        end
        bus.rd_en = 1'b0;
        n_checks++;
        if (pops != 8 || bus.count !== 4'd0 || bus.overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ovf_pops: pops=%0d count=%0d overflow=%b, required 8/0/1",
                     pops, bus.count, bus.overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_clear();
        for (int i = 1; i <= 8; i++) begin
            push(7'(i));
        end
        n_checks++;
        if (bus.count !== 4'd8 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL full_fill: count=%0d overflow=%b, required 8/0",
                     bus.count, bus.overflow);
        end
        bus.data_in    = 7'h09;
        bus.data_valid = 1'b1;
        bus.rd_en      = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        n_checks++;
        if (bus.rd_data !== 7'h01 || bus.rd_valid !== 1'b1 || bus.count !== 4'd8 ||
            bus.overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL full_pushpop: rd_data=%h rd_valid=%b count=%0d overflow=%b, required 01/1/8/0",
                     bus.rd_data, bus.rd_valid, bus.count, bus.overflow);
        end
        for (int i = 2; i <= 9; i++) begin
            tick();
            n_checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== 7'(i)) begin
                n_fail++;
                $display("[TB] FAIL full_wrap_pop: rd_valid=%b rd_data=%h, required 1/%h",
                         bus.rd_valid, bus.rd_data, 7'(i));
            end
        end
        bus.rd_en = 1'b0;
        n_checks++;
        if (bus.count !== 4'd0 || bus.rx_total !== 8'd9 || bus.checksum !== 8'h2D) begin
            n_fail++;
            $display("[TB] FAIL full_totals: count=%0d rx_total=%0d checksum=%h, required 0/9/2D",
                     bus.count, bus.rx_total, bus.checksum);
        end
    endtask

    task automatic test_done_with_data();
        do_clear();
        push(7'h04);
        bus.data_in    = 7'h05;
        bus.data_valid = 1'b1;
        bus.done_in    = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        bus.done_in    = 1'b0;
        n_checks++;
        if (bus.count !== 4'd2 || bus.rx_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL done_data: count=%0d rx_done=%b, required 2/1",
                     bus.count, bus.rx_done);
        end
        push(7'h06);
        n_checks++;
        if (bus.count !== 4'd2 || bus.rx_total !== 8'd2 || bus.checksum !== 8'h09) begin
            n_fail++;
            $display("[TB] FAIL done_ignore: count=%0d rx_total=%0d checksum=%h, required 2/2/09",
                     bus.count, bus.rx_total, bus.checksum);
        end
        bus.rd_en = 1'b1;
        tick();
        n_checks++;
        if (bus.rd_data !== 7'h04) begin
            n_fail++;
            $display("[TB] FAIL done_pop0: rd_data=%h, required 04", bus.rd_data);
        end
        tick();
        bus.rd_en = 1'b0;
        n_checks++;
        if (bus.rd_data !== 7'h05 || bus.rd_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL done_pop1: rd_data=%h rd_valid=%b, required 05/1",
                     bus.rd_data, bus.rd_valid);
        end
    endtask

    task automatic test_clear_priority();
        do_clear();
        for (int i = 1; i <= 4; i++) begin
            push(7'(i));
        end
        n_checks++;
        if (bus.count !== 4'd4 || bus.rx_done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clr_setup: count=%0d rx_done=%b, required 4/0",
                     bus.count, bus.rx_done);
        end
        bus.clear      = 1'b1;
        bus.data_in    = 7'h07;
        bus.data_valid = 1'b1;
        bus.rd_en      = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (bus.count !== 4'd0 || bus.checksum !== 8'h00 || bus.rx_total !== 8'h00 ||
            bus.overflow !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rx_done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clr_state: count=%0d checksum=%h rx_total=%0d overflow=%b rd_valid=%b rx_done=%b, required all 0",
                     bus.count, bus.checksum, bus.rx_total, bus.overflow, bus.rd_valid, bus.rx_done);
        end
        n_checks++;
        if (bus.rd_data !== 7'h05) begin
            n_fail++;
            $display("[TB] FAIL clr_rd_data_kept: rd_data=%h, required 05", bus.rd_data);
        end
        push(7'h0A);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        n_checks++;
        if (bus.rd_data !== 7'h0A || bus.count !== 4'd0 || bus.checksum !== 8'h0A) begin
            n_fail++;
            $display("[TB] FAIL clr_restart: rd_data=%h count=%0d checksum=%h, required 0A/0/0A",
                     bus.rd_data, bus.count, bus.checksum);
        end
    endtask

    task automatic test_empty_pop_async_reset();
        do_clear();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        n_checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 7'h0A || bus.count !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL empty_pop: rd_valid=%b rd_data=%h count=%0d, required 0/0A/0",
                     bus.rd_valid, bus.rd_data, bus.count);
        end
        bus.data_in    = 7'h12;
        bus.data_valid = 1'b1;
        tick();
        bus.data_in = 7'h13;
        tick();
        n_checks++;
        if (bus.count !== 4'd2) begin
            n_fail++;
            $display("[TB] FAIL arst_setup: count=%0d, required 2", bus.count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.count !== 4'd0 || bus.rx_total !== 8'd0 || bus.checksum !== 8'd0 ||
            bus.overflow !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 7'd0 ||
            bus.rx_done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL arst_immediate: count=%0d rx_total=%0d checksum=%h overflow=%b rd_valid=%b rd_data=%h rx_done=%b, required all 0",
                     bus.count, bus.rx_total, bus.checksum, bus.overflow, bus.rd_valid,
                     bus.rd_data, bus.rx_done);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.count !== 4'd0 || bus.rx_total !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL arst_release: count=%0d rx_total=%0d, required 0/0",
                     bus.count, bus.rx_total);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_stream();
        test_overflow();
        test_full_push_pop();
        test_done_with_data();
        test_clear_priority();
        test_empty_pop_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
